// File: rtl/mix_grad_b.sv
//------------------------------------------------------------------------------
// mix_grad_b
//
// Bias-gradient accumulator for the mix layer backward pass. Consumes a
// serial stream of per-token output gradients (one element per cycle, DEPTH
// elements per token row) and sums each column over N_ROWS rows into an
// external gradient RAM using read-modify-write. The first row overwrites
// the RAM, so no clear pass is needed. valid rises once the whole batch has
// been written and stays high while run is held.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   run         level enable; low clears counters and the pipeline
//   din_valid   din holds a gradient element
//   din         signed fixed-point dy element
//   din_ready   block accepts din this cycle
//   raddr       gradient RAM read address
//   rdata_grad  RAM read data, valid one cycle after raddr
//   we          gradient RAM write enable (one pulse per element)
//   waddr       gradient RAM write address
//   wdata_grad  accumulated (saturated) gradient
//   valid       batch accumulation complete
//------------------------------------------------------------------------------
`ifndef N_LEN_W
`define N_LEN_W 16
`endif
`ifndef HID_DIM
`define HID_DIM 64
`endif

module mix_grad_b #(
   parameter int ADDR_WIDTH = 9,
   parameter int DEPTH      = 3*`HID_DIM,
   parameter int N_ROWS     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   input  logic                  din_valid,
   input  logic [`N_LEN_W-1:0]   din,
   output logic                  din_ready,
   output logic [ADDR_WIDTH-1:0] raddr,
   input  logic [`N_LEN_W-1:0]   rdata_grad,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [`N_LEN_W-1:0]   wdata_grad,
   output logic                  valid
);

   localparam int DW    = `N_LEN_W;
   localparam int COL_W = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
   localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

   localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

   // Sum at DW+1 bits; a sign mismatch between the top two bits is overflow.
   function automatic logic signed [DW-1:0] sat_add(
      input logic signed [DW-1:0] a,
      input logic signed [DW-1:0] b
   );
      logic signed [DW:0] s;
      s = (DW+1)'(a) + (DW+1)'(b);
      if (s[DW] != s[DW-1])
         return s[DW] ? SAT_MIN : SAT_MAX;
      return s[DW-1:0];
   endfunction

   logic             r_all_acc;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;

   logic                   r_vld_p1;
   logic signed [DW-1:0]   r_din_p1;
   logic [COL_W-1:0]       r_col_p1;
   logic                   r_first_p1;
   logic                   r_last_p1;

   logic                   r_vld_p2;
   logic signed [DW-1:0]   r_din_p2;
   logic [COL_W-1:0]       r_col_p2;
   logic                   r_first_p2;
   logic                   r_last_p2;

   logic                   r_last_wr;

   logic                   w_accept;
   logic                   w_col_last;
   logic                   w_row_last;
   logic signed [DW-1:0]   w_din;
   logic signed [DW-1:0]   w_rdata;

   assign din_ready  = run & ~r_all_acc;
   assign w_accept   = din_valid & din_ready;
   assign w_col_last = (r_col == COL_W'(DEPTH-1));
   assign w_row_last = (r_row == ROW_W'(N_ROWS-1));
   assign w_din      = din;
   assign w_rdata    = rdata_grad;

   // ---- stage p0: accept, column/row counters, RAM read issue ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col     <= '0;
         r_row     <= '0;
         r_all_acc <= 1'b0;
         raddr     <= '0;
      end else if (!run) begin
         r_col     <= '0;
         r_row     <= '0;
         r_all_acc <= 1'b0;
         raddr     <= '0;
      end else if (w_accept) begin
         raddr <= ADDR_WIDTH'(r_col);
         if (w_col_last) begin
            r_col <= '0;
            if (w_row_last) begin
               r_row     <= '0;
               r_all_acc <= 1'b1;
            end else begin
               r_row <= r_row + 1'b1;
            end
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // ---- stage p1: element waits for the RAM read ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p1   <= 1'b0;
         r_din_p1   <= '0;
         r_col_p1   <= '0;
         r_first_p1 <= 1'b0;
         r_last_p1  <= 1'b0;
      end else begin
         // w_accept already implies run, so run low empties this stage.
         r_vld_p1 <= w_accept;
         if (w_accept) begin
            r_din_p1   <= w_din;
            r_col_p1   <= r_col;
            r_first_p1 <= (r_row == '0);
            r_last_p1  <= w_col_last & w_row_last;
         end
      end
   end

   // ---- stage p2: rdata_grad is valid alongside this stage ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p2   <= 1'b0;
         r_din_p2   <= '0;
         r_col_p2   <= '0;
         r_first_p2 <= 1'b0;
         r_last_p2  <= 1'b0;
      end else begin
         r_vld_p2 <= run & r_vld_p1;
         if (r_vld_p1) begin
            r_din_p2   <= r_din_p1;
            r_col_p2   <= r_col_p1;
            r_first_p2 <= r_first_p1;
            r_last_p2  <= r_last_p1;
         end
      end
   end

   // ---- write-back: first row overwrites stale RAM, later rows accumulate ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we         <= 1'b0;
         waddr      <= '0;
         wdata_grad <= '0;
         r_last_wr  <= 1'b0;
         valid      <= 1'b0;
      end else begin
         we        <= run & r_vld_p2;
         r_last_wr <= run & r_vld_p2 & r_last_p2;
         // valid follows the edge on which the final write lands in RAM.
         valid     <= run & (valid | r_last_wr);
         if (run && r_vld_p2) begin
            waddr      <= ADDR_WIDTH'(r_col_p2);
            wdata_grad <= r_first_p2 ? r_din_p2 : sat_add(w_rdata, r_din_p2);
         end
      end
   end

endmodule
